// File: rtl/neopixel_pkg.sv
// Shared WS2812 timing constants, error codes and the ns-to-cycle helper,
// used by both the neopixel driver and the neopixel receiver.
package neopixel_pkg;

    // Nominal transmit high times (driver side)
    localparam int unsigned T0H_NS     = 400;
    localparam int unsigned T1H_NS     = 800;

    // Receive classification thresholds
    localparam int unsigned T_MIN_NS   = 200;    // shorter high is a glitch
    localparam int unsigned T_SPLIT_NS = 600;    // high >= this is a '1'
    localparam int unsigned T_MAX_NS   = 1100;   // high reaching this is stuck
    localparam int unsigned T_LATCH_NS = 50000;  // low this long ends a frame

    // Error codes reported on error_code
    localparam logic [1:0] ERR_OVERFLOW   = 2'd0;
    localparam logic [1:0] ERR_SHORT_HIGH = 2'd1;
    localparam logic [1:0] ERR_LONG_HIGH  = 2'd2;
    localparam logic [1:0] ERR_PARTIAL    = 2'd3;

    typedef enum logic [1:0] {
        S_ARM,
        S_LOW,
        S_HIGH
    } rx_state_t;

    // Convert a duration in ns to whole clock cycles (truncating)
    function automatic int unsigned ns_to_cycles(input longint unsigned freq_hz,
                                                 input longint unsigned ns);
        longint unsigned cyc;
        cyc = (freq_hz * ns) / 64'd1_000_000_000;
        return 32'(cyc);
    endfunction

endpackage

// File: rtl/neopixel_sync.sv
// Two-flop synchronizer for the asynchronous pixel line plus edge detection
// on the synchronized level.
module neopixel_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Two metastability flops, a third holds the previous synced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~sync_p2;
    assign fall  = ~sync_p1 & sync_p2;

endmodule

// File: rtl/neopixel_rx.sv
// WS2812 one-wire receiver: measures high/low times of the synchronized line,
// assembles 24-bit GRB words, and reports pixels, frame latches and errors.
module neopixel_rx
    import neopixel_pkg::*;
#(
    parameter int unsigned C_FREQ_HZ = 125000000,
    parameter int          C_PIXELS  = 12,
    localparam int         IW        = $clog2(C_PIXELS + 1)
) (
    input  logic          neopixel_clock,
    input  logic          neopixel_reset,
    input  logic          neopixel_din,
    output logic          pixel_valid,
    output logic [IW-1:0] pixel_index,
    output logic [23:0]   pixel_data,
    output logic          frame_done,
    output logic [IW-1:0] frame_pixels,
    output logic          error,
    output logic [1:0]    error_code
);

    localparam int unsigned T_MIN   = ns_to_cycles(64'(C_FREQ_HZ), 64'(T_MIN_NS));
    localparam int unsigned T_SPLIT = ns_to_cycles(64'(C_FREQ_HZ), 64'(T_SPLIT_NS));
    localparam int unsigned T_MAX   = ns_to_cycles(64'(C_FREQ_HZ), 64'(T_MAX_NS));
    localparam int unsigned T_LATCH = ns_to_cycles(64'(C_FREQ_HZ), 64'(T_LATCH_NS));

    // One counter times both high and low phases; T_LATCH is the largest value
    localparam int CW = $clog2(T_LATCH + 1);

    localparam logic [CW-1:0] T_MIN_C   = CW'(T_MIN);
    localparam logic [CW-1:0] T_SPLIT_C = CW'(T_SPLIT);
    localparam logic [CW-1:0] T_MAX_C   = CW'(T_MAX);
    localparam logic [CW-1:0] T_LATCH_C = CW'(T_LATCH);
    localparam logic [IW-1:0] PIX_MAX   = IW'(C_PIXELS);

    logic          level;
    logic          rise;
    logic          fall;
    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [4:0]    bit_cnt;
    logic [IW-1:0] pix_cnt;
    logic [23:0]   shreg;
    logic          bit_val;
    logic          bit_ok;
    logic [23:0]   next_word;

    neopixel_sync u_sync (
        .clk   (neopixel_clock),
        .rst   (neopixel_reset),
        .din   (neopixel_din),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    // A falling edge ending a high that was long enough classifies one bit
    assign bit_val   = (cnt >= T_SPLIT_C);
    assign bit_ok    = (state == S_HIGH) && fall && (cnt >= T_MIN_C);
    assign next_word = {shreg[22:0], bit_val};

    // Bit shift register; a full word always overwrites it, so no reset needed
    always_ff @(posedge neopixel_clock) begin
        if (bit_ok) begin
            shreg <= next_word;
        end
    end

    // Receive FSM: arming, low/high timing, word/frame bookkeeping, outputs
    always_ff @(posedge neopixel_clock or posedge neopixel_reset) begin
        if (neopixel_reset) begin
            state        <= S_ARM;
            cnt          <= '0;
            bit_cnt      <= '0;
            pix_cnt      <= '0;
            pixel_valid  <= 1'b0;
            pixel_index  <= '0;
            pixel_data   <= '0;
            frame_done   <= 1'b0;
            frame_pixels <= '0;
            error        <= 1'b0;
            error_code   <= '0;
        end else begin
            pixel_valid <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            case (state)
                S_ARM: begin
                    // Wait for a full latch-length low so we never start mid-stream
                    bit_cnt <= '0;
                    pix_cnt <= '0;
                    if (level) begin
                        cnt <= '0;
                    end else if (cnt == T_LATCH_C - CW'(1)) begin
                        cnt   <= T_LATCH_C;
                        state <= S_LOW;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state <= S_HIGH;
                        cnt   <= CW'(1);
                    end else if (cnt == T_LATCH_C - CW'(1)) begin
                        // Latch reached; counter then saturates so this fires once
                        cnt <= T_LATCH_C;
                        if (bit_cnt != 5'd0) begin
                            error      <= 1'b1;
                            error_code <= ERR_PARTIAL;
                        end else if (pix_cnt != '0) begin
                            frame_done   <= 1'b1;
                            frame_pixels <= pix_cnt;
                        end
                        bit_cnt <= '0;
                        pix_cnt <= '0;
                    end else if (cnt != T_LATCH_C) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        if (cnt < T_MIN_C) begin
                            error      <= 1'b1;
                            error_code <= ERR_SHORT_HIGH;
                            cnt        <= '0;
                            state      <= S_ARM;
                        end else begin
                            state <= S_LOW;
                            cnt   <= CW'(1);
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                if (pix_cnt == PIX_MAX) begin
                                    // Frame already full: drop the word, keep going
                                    error      <= 1'b1;
                                    error_code <= ERR_OVERFLOW;
                                end else begin
                                    pixel_valid <= 1'b1;
                                    pixel_index <= pix_cnt;
                                    pixel_data  <= next_word;
                                    pix_cnt     <= pix_cnt + IW'(1);
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end else if (cnt == T_MAX_C - CW'(1)) begin
                        // Line stuck high: abort without waiting for the fall
                        error      <= 1'b1;
                        error_code <= ERR_LONG_HIGH;
                        cnt        <= '0;
                        state      <= S_ARM;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_ARM;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_rx.sv
// Scoreboard bench for neopixel_rx at 125 MHz with 12 pixels per frame.
module tb_neopixel_rx;

    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          din;
    logic          pixel_valid;
    logic [IW-1:0] pixel_index;
    logic [23:0]   pixel_data;
    logic          frame_done;
    logic [IW-1:0] frame_pixels;
    logic          error;
    logic [1:0]    error_code;

    int n_compared   = 0;
    int n_mismatched = 0;

    // kind: 0 pixel, 1 frame_done, 2 error
    typedef struct {
        int          kind;
        int          idx;
        logic [23:0] data;
        int          aux;
    } exp_t;

    exp_t sb[$];

    // Overflow-frame words; [0] is sent with boundary-length pulses in its top 4 bits
    logic [23:0] px [13] = '{24'h55A5A5, 24'h111111, 24'h222222, 24'h333333,
                             24'h444444, 24'h555555, 24'h666666, 24'h777777,
                             24'h888888, 24'h999999, 24'hAAAAAA, 24'hBBBBBB,
                             24'hCCCCCC};

    neopixel_rx #(
        .C_FREQ_HZ (125000000),
        .C_PIXELS  (12)
    ) dut (
        .neopixel_clock (clk),
        .neopixel_reset (rst),
        .neopixel_din   (din),
        .pixel_valid    (pixel_valid),
        .pixel_index    (pixel_index),
        .pixel_data     (pixel_data),
        .frame_done     (frame_done),
        .frame_pixels   (frame_pixels),
        .error          (error),
        .error_code     (error_code)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_pix(input int idx, input logic [23:0] data);
        exp_t e;
        e.kind = 0; e.idx = idx; e.data = data; e.aux = 0;
        sb.push_back(e);
    endtask

    task automatic exp_frame(input int n);
        exp_t e;
        e.kind = 1; e.idx = 0; e.data = '0; e.aux = n;
        sb.push_back(e);
    endtask

    task automatic exp_err(input int code);
        exp_t e;
        e.kind = 2; e.idx = 0; e.data = '0; e.aux = code;
        sb.push_back(e);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pixel_valid"},  32'(pixel_valid),  32'd0);
        check({tag, "_pixel_index"},  32'(pixel_index),  32'd0);
        check({tag, "_pixel_data"},   32'(pixel_data),   32'd0);
        check({tag, "_frame_done"},   32'(frame_done),   32'd0);
        check({tag, "_frame_pixels"}, 32'(frame_pixels), 32'd0);
        check({tag, "_error"},        32'(error),        32'd0);
        check({tag, "_error_code"},   32'(error_code),   32'd0);
    endtask

    task automatic hold(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int h, input int l);
        hold(1'b1, h);
        hold(1'b0, l);
    endtask

    // Send the low nbits of w, MSB first; l0/l1 are the low times after a 0/1
    task automatic send_bits(input logic [23:0] w, input int nbits, input int l0, input int l1);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (w[i]) send_pulse(100, l1);
            else      send_pulse(50, l0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports an event
    always @(negedge clk) begin
        int   n;
        int   kind;
        exp_t e;
        n = int'(pixel_valid) + int'(frame_done) + int'(error);
        if (n > 1) check("single_event", 32'(n), 32'd1);
        if (n != 0) begin
            kind = pixel_valid ? 0 : (frame_done ? 1 : 2);
            if (sb.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL unexpected_event: kind %0d idx %0d data 0x%0h code %0d, none required (t=%0t)",
                         kind, pixel_index, pixel_data, error_code, $time);
            end else begin
                e = sb.pop_front();
                check("event_kind", 32'(kind), e.kind);
                if (kind == e.kind) begin
                    case (kind)
                        0: begin
                            check("pixel_index", 32'(pixel_index), e.idx);
                            check("pixel_data", 32'(pixel_data), 32'(e.data));
                        end
                        1: check("frame_pixels", 32'(frame_pixels), e.aux);
                        default: begin
                            check("error_code", 32'(error_code), e.aux);
                            if (e.aux == 2) check("long_high_still_high", 32'(din), 32'd1);
                        end
                    endcase
                end
            end
        end
    end

    initial begin
        din = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // Basic two-pixel frame with nominal bit shapes
        hold(1'b0, 7000);
        exp_pix(0, 24'h00FF00);
        exp_pix(1, 24'hA5A5A5);
        exp_frame(2);
        send_bits(24'h00FF00, 24, 106, 56);
        send_bits(24'hA5A5A5, 24, 106, 56);
        hold(1'b0, 6300);
        check("frame_pixels_held", 32'(frame_pixels), 32'd2);

        // Line stuck high: error reported while the line is still high
        exp_err(2);
        send_pulse(200, 40);

        // Async reset while a stream is running; nothing decodes until re-armed
        send_bits(24'h5, 3, 30, 30);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("midreset");
        send_bits(24'h3, 2, 30, 30);
        rst = 1'b0;
        send_bits(24'h6, 3, 30, 30);
        send_pulse(20, 30);
        hold(1'b0, 6300);

        // Glitch-length high after two bits
        send_bits(24'h2, 2, 30, 30);
        exp_err(1);
        send_pulse(20, 100);
        hold(1'b0, 6300);

        // 13 pixels into a 12-pixel frame; pixel 0 carries 74/75/25/136 pulses.
        // Lows inside a frame are not timed, so short lows keep this frame brief.
        for (int i = 0; i < 12; i++) exp_pix(i, px[i]);
        exp_err(0);
        exp_frame(12);
        send_pulse(74, 30);
        send_pulse(75, 30);
        send_pulse(25, 30);
        send_pulse(136, 30);
        send_bits(px[0], 20, 30, 30);
        for (int i = 1; i < 13; i++) send_bits(px[i], 24, 30, 30);
        hold(1'b0, 6300);
        check("frame_pixels_overflow", 32'(frame_pixels), 32'd12);

        // One full pixel then a 10-bit partial word: partial error, no frame_done
        exp_pix(0, 24'h0F0F0F);
        exp_err(3);
        send_bits(24'h0F0F0F, 24, 30, 30);
        send_bits(24'h2AA, 10, 30, 30);
        hold(1'b0, 6300);
        check("frame_pixels_after_partial", 32'(frame_pixels), 32'd12);

        for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
